// File: rtl/bnn_conv3x3_xnor.sv
// 3x3 binary convolution stage: assembles windows from line-buffer columns,
// computes XNOR-popcount against a 9-bit kernel and thresholds the result.
module bnn_conv3x3_xnor #(
  parameter int W0    = 28,
  parameter int W1    = 12,
  parameter int CNT_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       state,
  input  logic       start,
  input  logic [2:0] taps,
  input  logic [8:0] weight,
  input  logic [3:0] thresh,
  output logic       dout,
  output logic [3:0] pop,
  output logic       dout_valid,
  output logic       frame_done,
  output logic       busy
);

  localparam int COL_W = $clog2(W0);

  localparam logic [CNT_W-1:0] FILL_END0 = CNT_W'(3 * W0 - 1);
  localparam logic [CNT_W-1:0] FILL_END1 = CNT_W'(3 * W1 - 1);
  localparam logic [CNT_W-1:0] LAST0     = CNT_W'(W0 * W0 + W0 - 1);
  localparam logic [CNT_W-1:0] LAST1     = CNT_W'(W1 * W1 + W1 - 1);
  localparam logic [COL_W-1:0] COL_END0  = COL_W'(W0 - 1);
  localparam logic [COL_W-1:0] COL_END1  = COL_W'(W1 - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DONE
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] i_q, i_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [2:0]       col0_q, col0_d, col1_q, col1_d, col2_q, col2_d;
  logic             win_valid_q, win_valid_d;
  logic             last_q, last_d;
  logic             dout_q, dout_d;
  logic [3:0]       pop_q, pop_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_done_q, frame_done_d;

  logic [CNT_W-1:0] fill_end, last_end;
  logic [COL_W-1:0] col_end;
  logic             sample;
  logic             out_upd;
  logic [8:0]       win;
  logic [8:0]       xn;
  logic [3:0]       pop_next;

  assign fill_end = mode_q ? FILL_END1 : FILL_END0;
  assign last_end = mode_q ? LAST1 : LAST0;
  assign col_end  = mode_q ? COL_END1 : COL_END0;
  assign sample   = start && ((fsm_q == FILL) || (fsm_q == RUN));

  // Row-major window: columns are oldest (left) to newest (right), bit2 = top.
  assign win = {col0_q[2], col1_q[2], col2_q[2],
                col0_q[1], col1_q[1], col2_q[1],
                col0_q[0], col1_q[0], col2_q[0]};

  always_comb begin
    xn       = ~(win ^ weight);
    pop_next = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      pop_next = pop_next + {3'b000, xn[k]};
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    mode_d      = mode_q;
    i_d         = i_q;
    col_d       = col_q;
    col0_d      = col0_q;
    col1_d      = col1_q;
    col2_d      = col2_q;
    win_valid_d = 1'b0;
    last_d      = 1'b0;

    // A window in flight when a new frame is armed must not reach the outputs.
    out_upd      = win_valid_q && !frame_start;
    dout_valid_d = out_upd;
    frame_done_d = out_upd && last_q;
    pop_d        = out_upd ? pop_next : pop_q;
    dout_d       = out_upd ? (pop_next >= thresh) : dout_q;

    if (frame_start) begin
      fsm_d  = FILL;
      mode_d = state;
      i_d    = '0;
      col_d  = '0;
      col0_d = '0;
      col1_d = '0;
      col2_d = '0;
    end else if (sample) begin
      i_d = i_q + CNT_W'(1);
      if (fsm_q == FILL) begin
        if (i_q == fill_end) fsm_d = RUN;
      end else begin
        col0_d      = col1_q;
        col1_d      = col2_q;
        col2_d      = taps;
        win_valid_d = (col_q >= COL_W'(2));
        col_d       = (col_q == col_end) ? '0 : col_q + COL_W'(1);
        if (i_q == last_end) begin
          fsm_d  = DONE;
          last_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q        <= IDLE;
      mode_q       <= 1'b0;
      i_q          <= '0;
      col_q        <= '0;
      col0_q       <= '0;
      col1_q       <= '0;
      col2_q       <= '0;
      win_valid_q  <= 1'b0;
      last_q       <= 1'b0;
      dout_q       <= 1'b0;
      pop_q        <= '0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      mode_q       <= mode_d;
      i_q          <= i_d;
      col_q        <= col_d;
      col0_q       <= col0_d;
      col1_q       <= col1_d;
      col2_q       <= col2_d;
      win_valid_q  <= win_valid_d;
      last_q       <= last_d;
      dout_q       <= dout_d;
      pop_q        <= pop_d;
      dout_valid_q <= dout_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dout       = dout_q;
  assign pop        = pop_q;
  assign dout_valid = dout_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (fsm_q == FILL) || (fsm_q == RUN);

endmodule

// File: tb/tb_bnn_conv3x3_xnor.sv
// Bench for bnn_conv3x3_xnor: drives image columns frame by frame and checks
// every output cycle against a direct 3x3 XNOR-popcount over the image.
module tb_bnn_conv3x3_xnor;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       state;
  logic       start;
  logic [2:0] taps;
  logic [8:0] weight;
  logic [3:0] thresh;
  logic       dout;
  logic [3:0] pop;
  logic       dout_valid;
  logic       frame_done;
  logic       busy;

  bnn_conv3x3_xnor #(.W0(28), .W1(12), .CNT_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .state      (state),
    .start      (start),
    .taps       (taps),
    .weight     (weight),
    .thresh     (thresh),
    .dout       (dout),
    .pop        (pop),
    .dout_valid (dout_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int pop;
    bit dout;
    bit last;
  } exp_t;

  exp_t q[$];
  logic img [0:27][0:27];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cur_w, drv_i, k86;
  int obs_cnt, fd_cnt, first_valid_cyc;
  int obs_pop [0:3];
  bit obs_dout [0:3];
  bit   exp_v;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_val);
    total++;
    if (act != exp_val) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_val, $time);
    end
  endtask

  // Reference: pixel match count over rows r..r+2, columns c-2..c.
  function automatic int exp_pop(input int r, input int c);
    int p = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        if (img[r+dr][c-2+dc] == weight[8-(dr*3+dc)]) p++;
    return p;
  endfunction

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      exp_v = (q.size() > 0) && (q[0].cyc == cyc);
      chk("dout_valid", int'(dout_valid), int'(exp_v));
      if (exp_v) begin
        e = q.pop_front();
        chk("pop", int'(pop), e.pop);
        chk("dout", int'(dout), int'(e.dout));
        chk("frame_done", int'(frame_done), int'(e.last));
      end else begin
        chk("frame_done_idle", int'(frame_done), 0);
      end
      if (dout_valid) begin
        if (obs_cnt < 4) begin
          obs_pop[obs_cnt]  = int'(pop);
          obs_dout[obs_cnt] = dout;
        end
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        obs_cnt++;
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic do_frame_start(input logic m, input logic coinc);
    frame_start = 1'b1;
    state       = m;
    start       = coinc;
    taps        = 3'($urandom);
    q.delete();
    cur_w           = m ? 12 : 28;
    drv_i           = 0;
    obs_cnt         = 0;
    fd_cnt          = 0;
    first_valid_cyc = -1;
    @(negedge clk);
    frame_start = 1'b0;
    start       = 1'b0;
    chk("busy_armed", int'(busy), 1);
  endtask

  task automatic shift();
    int r, c;
    start = 1'b1;
    if (drv_i >= 3 * cur_w) begin
      r    = (drv_i - 3 * cur_w) / cur_w;
      c    = (drv_i - 3 * cur_w) % cur_w;
      taps = {img[r][c], img[r+1][c], img[r+2][c]};
      if (c >= 2) begin
        e.cyc  = cyc + 2;
        e.pop  = exp_pop(r, c);
        e.dout = (e.pop >= int'(thresh));
        e.last = (drv_i == cur_w * cur_w + cur_w - 1);
        q.push_back(e);
      end
    end else begin
      taps = 3'($urandom);
    end
    if (drv_i == 86) k86 = cyc;
    drv_i++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_samples(input int n, input int gap_every);
    for (int k = 0; k < n; k++) begin
      shift();
      if (gap_every > 0 && (k % gap_every) == gap_every - 1) @(negedge clk);
    end
  endtask

  task automatic finish_frame(input int exp_cnt);
    repeat (4) @(negedge clk);
    chk("out_count", obs_cnt, exp_cnt);
    chk("frame_done_count", fd_cnt, 1);
    chk("busy_after", int'(busy), 0);
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic fill_img(input int kind);
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        case (kind)
          0:       img[r][c] = 1'b1;
          1:       img[r][c] = ((r + c) % 2) == 0;
          default: img[r][c] = 1'($urandom);
        endcase
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; state = 1'b0; start = 1'b0;
    taps = '0; weight = '0; thresh = '0;
    cur_w = 28; drv_i = 0; k86 = 0;
    obs_cnt = 0; fd_cnt = 0; first_valid_cyc = -1;
    #1;
    chk("reset_dout_valid", int'(dout_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pop", int'(pop), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-RUN, then start pulses without frame_start.
    fill_img(2); weight = 9'h0F3; thresh = 4'd4;
    do_frame_start(1'b0, 1'b0);
    run_samples(100, 0);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    chk("async_dout", int'(dout), 0);
    chk("async_pop", int'(pop), 0);
    chk("async_dout_valid", int'(dout_valid), 0);
    chk("async_frame_done", int'(frame_done), 0);
    chk("async_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    obs_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      start = 1'b1; taps = 3'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_outputs", obs_cnt, 0);
    chk("idle_busy", int'(busy), 0);

    // 28x28 all ones, matching kernel, highest threshold.
    fill_img(0); weight = 9'h1FF; thresh = 4'd9;
    do_frame_start(1'b0, 1'b0);
    run_samples(812, 0);
    finish_frame(676);
    chk("first_latency", first_valid_cyc - k86, 2);
    chk("allones_pop0", obs_pop[0], 9);
    chk("allones_dout0", int'(obs_dout[0]), 1);

    // 12x12 checkerboard against checkerboard kernel.
    fill_img(1); weight = 9'h155; thresh = 4'd5;
    do_frame_start(1'b1, 1'b0);
    run_samples(156, 0);
    finish_frame(100);
    chk("checker_pop0", obs_pop[0], 9);
    chk("checker_pop1", obs_pop[1], 0);
    chk("checker_dout0", int'(obs_dout[0]), 1);
    chk("checker_dout1", int'(obs_dout[1]), 0);

    // 28x28 random image with start gaps.
    fill_img(2); weight = 9'h0B6; thresh = 4'd5;
    do_frame_start(1'b0, 1'b0);
    run_samples(812, 3);
    finish_frame(676);

    // Threshold corners on 12x12 all-ones.
    fill_img(0); weight = 9'h000; thresh = 4'd1;
    do_frame_start(1'b1, 1'b0);
    run_samples(156, 0);
    finish_frame(100);
    chk("w0_t1_pop", obs_pop[0], 0);
    chk("w0_t1_dout", int'(obs_dout[0]), 0);

    thresh = 4'd0;
    do_frame_start(1'b1, 1'b0);
    run_samples(156, 0);
    finish_frame(100);
    chk("w0_t0_dout", int'(obs_dout[0]), 1);

    weight = 9'h1FF; thresh = 4'd10;
    do_frame_start(1'b1, 1'b0);
    run_samples(156, 0);
    finish_frame(100);
    chk("w1ff_t10_pop", obs_pop[0], 9);
    chk("w1ff_t10_dout", int'(obs_dout[0]), 0);

    // Restart mid-RUN with geometry change and a coincident shift.
    fill_img(2); weight = 9'h13C; thresh = 4'd6;
    do_frame_start(1'b0, 1'b0);
    run_samples(150, 0);
    do_frame_start(1'b1, 1'b1);
    run_samples(156, 0);
    finish_frame(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
